// File: rtl/branch_flag_ctrl_if.sv
// Bundle between the compare/condition stages and branch_flag_ctrl; optional link fields need BRANCH_LINK_EN.
// master = upstream pipeline driving requests, slave = branch_flag_ctrl.
interface branch_flag_ctrl_if #(
    parameter int PC_W   = 16,
    parameter int FLAG_W = 4
);
    logic              stall;
    logic              cmp_valid;
    logic [FLAG_W-1:0] flag_in;
    logic [FLAG_W-1:0] flag_q;
    logic              branch_valid;
    logic [PC_W-1:0]   branch_target;
    logic              cond_ok;
    logic              halt_req;
    logic [PC_W-1:0]   pc;
    logic              flush;
    logic              halted;
`ifdef BRANCH_LINK_EN
    logic              branch_link;
    logic [PC_W-1:0]   link_q;
`endif

    modport master (
        output stall, cmp_valid, flag_in, branch_valid, branch_target, cond_ok, halt_req,
`ifdef BRANCH_LINK_EN
        output branch_link,
        input  link_q,
`endif
        input  flag_q, pc, flush, halted
    );

    modport slave (
        input  stall, cmp_valid, flag_in, branch_valid, branch_target, cond_ok, halt_req,
`ifdef BRANCH_LINK_EN
        input  branch_link,
        output link_q,
`endif
        output flag_q, pc, flush, halted
    );
endinterface

// File: rtl/branch_flag_ctrl.sv
// Flag register + PC sequencer with RUN/FLUSH/HALT FSM; BRANCH_LINK_EN adds a return-address register.
// Latency: branch decision -> new pc in 1 cycle, taken branch adds one FLUSH bubble.
// Backpressure: stall freezes every register (state, pc, flags, link) for that cycle.
module branch_flag_ctrl #(
    parameter int              PC_W     = 16,
    parameter int              FLAG_W   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_flag_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic              flush_q, flush_d;
    logic              halted_q, halted_d;
    logic [PC_W-1:0]   pc_inc;
    logic              taken;
`ifdef BRANCH_LINK_EN
    logic [PC_W-1:0]   link_q, link_d;
`endif

    assign pc_inc = pc_q + PC_W'(1);
    assign taken  = bus.branch_valid & bus.cond_ok;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
`ifdef BRANCH_LINK_EN
        link_d  = link_q;
`endif
        if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    // cond_ok was derived from the old flag_q, so capturing new flags here is safe.
                    if (bus.cmp_valid) flag_d = bus.flag_in;
                    if (bus.halt_req) begin
                        state_d = ST_HALT;
                    end else if (taken) begin
                        pc_d    = bus.branch_target;
                        state_d = ST_FLUSH;
`ifdef BRANCH_LINK_EN
                        if (bus.branch_link) link_d = pc_inc;
`endif
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                // Squashed slot: branch/cmp/halt requests are ignored here.
                ST_FLUSH: begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
                default: ;
            endcase
        end
        flush_d  = (state_d == ST_FLUSH);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flag_q   <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef BRANCH_LINK_EN
            link_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flag_q   <= flag_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
`ifdef BRANCH_LINK_EN
            link_q   <= link_d;
`endif
        end
    end

    assign bus.flag_q = flag_q;
    assign bus.pc     = pc_q;
    assign bus.flush  = flush_q;
    assign bus.halted = halted_q;
`ifdef BRANCH_LINK_EN
    assign bus.link_q = link_q;
`endif
endmodule
